meas_sequencer: RTL and testbench

- Scheduler for the count-acquisition datapath, in the clk_12mhz domain.
- Steps the analog input multiplexer through a programmed channel mask.
- Waits a programmed settling time on each channel, measured in 5 ms ticks.
- Then passes a programmed number of 24-bit count results from the count prebuffer into the readout FIFO.
- Sits between main_ctrl (configuration/start/stop), count_prebufer (samples) and FIFO (write side).

---
 rtl/meas_sequencer.sv | 171 +++++++++++++++++
 tb/tb_meas_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_sequencer.sv
// Scan scheduler for the count-acquisition path: walks the channel mask, waits for
// the input to settle, then forwards a fixed number of count samples into the FIFO.
module meas_sequencer #(
  parameter int NCH      = 16,
  parameter int SEL_W    = 4,
  parameter int SETTLE_W = 8,
  parameter int CONV_W   = 8,
  parameter int DATA_W   = 24
) (
  input  logic              clk_12mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [SETTLE_W-1:0] settle_ticks,
  input  logic [CONV_W-1:0] conv_count,
  input  logic              tick_5ms,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              fifo_full,
  output logic [SEL_W-1:0]  input_sel,
  output logic              gate_en,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, MEASURE, NEXT, DONE} state_t;

  localparam logic [CONV_W-1:0]   CONV_ONE   = CONV_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [SEL_W:0]      PTR_ONE    = (SEL_W+1)'(1);

  state_t              state;
  logic [NCH-1:0]      mask_cfg;
  logic [SETTLE_W-1:0] settle_cfg;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [CONV_W-1:0]   conv_cfg;
  logic [CONV_W-1:0]   smp_cnt;
  logic                cont_cfg;
  logic [SEL_W:0]      ptr;
  logic [SEL_W:0]      sel_hit;
  logic [SEL_W:0]      nxt_hit;
  logic [SEL_W:0]      sel_inc;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [SEL_W:0] find_set(input logic [NCH-1:0] m,
                                              input logic [SEL_W:0] from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign sel_inc = {1'b0, input_sel} + PTR_ONE;
  assign sel_hit = find_set(mask_cfg, ptr);
  assign nxt_hit = find_set(mask_cfg, sel_inc);

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask_cfg   <= '0;
      settle_cfg <= '0;
      settle_cnt <= '0;
      conv_cfg   <= '0;
      smp_cnt    <= '0;
      cont_cfg   <= 1'b0;
      ptr        <= '0;
      input_sel  <= '0;
      gate_en    <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;
      // Abort wins over everything else, including a sample arriving this cycle.
      if (stop && (state != IDLE)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        gate_en <= 1'b0;
        done    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (chan_mask != '0) begin
                mask_cfg   <= chan_mask;
                settle_cfg <= settle_ticks;
                conv_cfg   <= (conv_count == '0) ? CONV_ONE : conv_count;
                cont_cfg   <= continuous;
                overrun    <= 1'b0;
                ptr        <= '0;
                busy       <= 1'b1;
                state      <= SELECT;
              end else begin
                done <= 1'b1;
              end
            end
          end
          SELECT: begin
            if (sel_hit[SEL_W]) begin
              input_sel  <= sel_hit[SEL_W-1:0];
              settle_cnt <= settle_cfg;
              smp_cnt    <= '0;
              state      <= SETTLE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          SETTLE: begin
            // The tick that brings the count to zero opens the gate right away.
            if ((settle_cnt == '0) || (tick_5ms && (settle_cnt == SETTLE_ONE))) begin
              settle_cnt <= '0;
              gate_en    <= 1'b1;
              state      <= MEASURE;
            end else if (tick_5ms) begin
              settle_cnt <= settle_cnt - SETTLE_ONE;
            end
          end
          MEASURE: begin
            if (sample_valid) begin
              if (fifo_full) begin
                overrun <= 1'b1;
              end else begin
                fifo_wr_en <= 1'b1;
                fifo_data  <= sample_data;
              end
              if (smp_cnt == (conv_cfg - CONV_ONE)) begin
                gate_en <= 1'b0;
                state   <= NEXT;
              end else begin
                smp_cnt <= smp_cnt + CONV_ONE;
              end
            end
          end
          NEXT: begin
            if (nxt_hit[SEL_W]) begin
              ptr   <= sel_inc;
              state <= SELECT;
            end else if (cont_cfg) begin
              ptr   <= '0;
              state <= SELECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            gate_en <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: a scan-level model predicts which samples land
// in the FIFO and on which channel; a monitor checks every FIFO write against it.
module tb_meas_sequencer;
  logic        clk_12mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] chan_mask = '0;
  logic [7:0]  settle_ticks = '0;
  logic [7:0]  conv_count = '0;
  logic        tick_man = 1'b0;
  logic        tick_auto = 1'b0;
  logic        tick_en = 1'b0;
  wire         tick_5ms;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = '0;
  logic        fifo_full = 1'b0;
  logic [3:0]  input_sel;
  logic        gate_en;
  logic        fifo_wr_en;
  logic [23:0] fifo_data;
  logic        busy;
  logic        done;
  logic        overrun;

  meas_sequencer #(.NCH(16), .SEL_W(4), .SETTLE_W(8), .CONV_W(8), .DATA_W(24)) dut (
    .clk_12mhz(clk_12mhz), .rst_n(rst_n), .start(start), .stop(stop),
    .continuous(continuous), .chan_mask(chan_mask), .settle_ticks(settle_ticks),
    .conv_count(conv_count), .tick_5ms(tick_5ms), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(fifo_full), .input_sel(input_sel),
    .gate_en(gate_en), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  assign tick_5ms = tick_man | tick_auto;

  int tcnt = 0;
  always begin
    @(posedge clk_12mhz);
    #1;
    tcnt++;
    tick_auto = tick_en && ((tcnt % 4) == 0);
  end

  typedef struct {
    logic [23:0] d;
    logic [3:0]  ch;
  } wr_t;

  wr_t exp_q[$];
  int  order[$];
  int  conv_m = 1;
  bit  cont_m = 1'b0;
  int  k_m = 0;
  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  int  done_seen = 0;

  // Scan model: channels in ascending mask order, conv samples each.
  function automatic void model_start(input logic [15:0] m, input logic [7:0] c, input bit cont);
    order.delete();
    for (int i = 0; i < 16; i++) if (m[i]) order.push_back(i);
    conv_m = (c == 0) ? 1 : int'(c);
    cont_m = cont;
    k_m    = 0;
  endfunction

  function automatic bit model_in_scan();
    return cont_m || (k_m < order.size() * conv_m);
  endfunction

  function automatic void model_sample(input logic [23:0] d, input bit full);
    wr_t e;
    e.d  = d;
    e.ch = 4'(order[(k_m / conv_m) % order.size()]);
    if (!full) exp_q.push_back(e);
    k_m++;
  endfunction

  always @(negedge clk_12mhz) begin
    wr_t e;
    if (rst_n) begin
      if (done) done_seen++;
      if (fifo_wr_en) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got data=%h sel=%0d, required no write", fifo_data, input_sel);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data !== e.d || input_sel !== e.ch) begin
            errors++;
            $display("FAIL write: got data=%h sel=%0d, required data=%h sel=%0d",
                     fifo_data, input_sel, e.d, e.ch);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk_12mhz);
      #1;
    end
  endtask

  // Start a scan, then scramble the config inputs to show they were latched.
  task automatic do_start(input logic [15:0] m, input logic [7:0] s, input logic [7:0] c, input bit cont);
    chan_mask = m; settle_ticks = s; conv_count = c; continuous = cont;
    start = 1'b1;
    tick_clk(1);
    start = 1'b0;
    if (m != 0) model_start(m, c, cont);
    chan_mask = 16'hFFFF; settle_ticks = 8'd9; conv_count = 8'd7; continuous = ~cont;
  endtask

  task automatic wait_gate();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (gate_en) ok = 1'b1;
      else tick_clk(1);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gate_timeout: gate_en stayed 0, required 1");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else tick_clk(1);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stayed 1, required 0");
    end
  endtask

  task automatic send(input logic [23:0] d, input bit full);
    sample_valid = 1'b1; sample_data = d; fifo_full = full;
    tick_clk(1);
    sample_valid = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic scan_sample(input logic [23:0] d, input bit full);
    if (model_in_scan()) begin
      wait_gate();
      model_sample(d, full);
    end
    send(d, full);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    // Reset state
    tick_clk(3);
    check("rst_busy", busy, 0);
    check("rst_gate", gate_en, 0);
    check("rst_sel", input_sel, 0);
    rst_n = 1'b1;
    tick_clk(1);
    check("idle_done", done, 0);
    check("idle_overrun", overrun, 0);

    // Single pass over channels 0 and 2, two extra samples after the scan
    tick_en = 1'b1;
    w0 = wr_seen; d0 = done_seen;
    do_start(16'h0005, 8'd2, 8'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) wait_idle();
      scan_sample(24'h100000 + 24'(i), 1'b0);
    end
    tick_clk(3);
    check("sp_writes", wr_seen - w0, 6);
    check("sp_done", done_seen - d0, 1);
    check("sp_busy", busy, 0);
    check("sp_last_sel", input_sel, 2);

    // Settle of 3 ticks: gate opens the cycle after the third tick
    tick_en = 1'b0;
    do_start(16'h0001, 8'd3, 8'd1, 1'b0);
    tick_clk(3);
    tick_man = 1'b1; tick_clk(1); tick_man = 1'b0;
    tick_clk(2);
    tick_man = 1'b1; tick_clk(1); tick_man = 1'b0;
    tick_clk(2);
    check("settle3_before", gate_en, 0);
    tick_man = 1'b1; tick_clk(1); tick_man = 1'b0;
    check("settle3_after", gate_en, 1);
    scan_sample(24'hA00001, 1'b0);
    wait_idle();

    // Settle of 0: gate rises two cycles after start
    do_start(16'h0001, 8'd0, 8'd1, 1'b0);
    check("settle0_c1", gate_en, 0);
    tick_clk(1);
    check("settle0_c2", gate_en, 0);
    tick_clk(1);
    check("settle0_c3", gate_en, 1);
    scan_sample(24'hA00002, 1'b0);
    wait_idle();

    // Overrun: FIFO full on the 2nd of 4 samples
    w0 = wr_seen; d0 = done_seen;
    do_start(16'h0001, 8'd0, 8'd4, 1'b0);
    scan_sample(24'hB00001, 1'b0);
    scan_sample(24'hB00002, 1'b1);
    scan_sample(24'hB00003, 1'b0);
    scan_sample(24'hB00004, 1'b0);
    check("ovr_flag", overrun, 1);
    wait_idle();
    tick_clk(1);
    check("ovr_writes", wr_seen - w0, 3);
    check("ovr_done", done_seen - d0, 1);
    check("ovr_kept", overrun, 1);
    do_start(16'h0001, 8'd0, 8'd1, 1'b0);
    check("ovr_cleared", overrun, 0);
    scan_sample(24'hB00005, 1'b0);
    wait_idle();

    // Continuous 0/15 wrap, then abort with a coincident sample
    do_start(16'h8001, 8'd0, 8'd1, 1'b1);
    scan_sample(24'hC00001, 1'b0);
    scan_sample(24'hC00002, 1'b0);
    check("cont_sel15", input_sel, 15);
    scan_sample(24'hC00003, 1'b0);
    scan_sample(24'hC00004, 1'b0);
    scan_sample(24'hC00005, 1'b0);
    check("cont_sel0", input_sel, 0);
    wait_gate();
    stop = 1'b1; sample_valid = 1'b1; sample_data = 24'hDEAD00;
    tick_clk(1);
    stop = 1'b0; sample_valid = 1'b0;
    check("stop_gate", gate_en, 0);
    check("stop_done", done, 1);
    check("stop_busy", busy, 0);
    check("stop_nowrite", fifo_wr_en, 0);
    tick_clk(1);
    check("stop_done_pulse", done, 0);

    // Start with empty mask: done only
    chan_mask = 16'h0000;
    start = 1'b1; tick_clk(1); start = 1'b0;
    check("mask0_done", done, 1);
    check("mask0_busy", busy, 0);
    tick_clk(1);
    check("mask0_done_pulse", done, 0);
    check("mask0_busy2", busy, 0);

    // Start while busy is ignored
    w0 = wr_seen;
    do_start(16'h0001, 8'd0, 8'd2, 1'b0);
    chan_mask = 16'h0002; conv_count = 8'd1;
    start = 1'b1; tick_clk(1); start = 1'b0;
    scan_sample(24'hD00001, 1'b0);
    scan_sample(24'hD00002, 1'b0);
    wait_idle();
    tick_clk(1);
    check("busy_start_writes", wr_seen - w0, 2);
    check("busy_start_sel", input_sel, 0);

    // conv_count of zero keeps one sample per channel
    tick_en = 1'b1;
    w0 = wr_seen;
    do_start(16'h0006, 8'd1, 8'd0, 1'b0);
    scan_sample(24'hE00001, 1'b0);
    scan_sample(24'hE00002, 1'b0);
    wait_idle();
    tick_clk(1);
    check("conv0_writes", wr_seen - w0, 2);
    check("conv0_sel", input_sel, 2);
    tick_en = 1'b0;

    // Asynchronous reset during MEASURE
    do_start(16'h0010, 8'd0, 8'd3, 1'b0);
    scan_sample(24'hF00001, 1'b0);
    wait_gate();
    @(negedge clk_12mhz);
    #2;
    sample_valid = 1'b1; sample_data = 24'hF00002;
    rst_n = 1'b0;
    #1;
    check("arst_gate", gate_en, 0);
    check("arst_busy", busy, 0);
    check("arst_sel", input_sel, 0);
    check("arst_wr", fifo_wr_en, 0);
    check("arst_data", fifo_data, 0);
    tick_clk(2);
    sample_valid = 1'b0;
    rst_n = 1'b1;
    tick_clk(2);
    check("arst_idle", busy, 0);
    check("pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
